// File: rtl/mips_multicycle_ctrl_if.sv
// Control/datapath bundle for the multicycle MIPS controller: IR fields, ALU flag and
// memory handshake in, mux selects, strobes and status pulses out.
interface mips_multicycle_ctrl_if;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       Zero;
    logic       mem_ready;
    logic [3:0] ALUControl;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic       ext_zero;
    logic [1:0] PCSource;
    logic       pc_en;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       IRWrite;
    logic       RegDst;
    logic       MemtoReg;
    logic       RegWrite;
    logic       instr_done;
    logic       illegal_instr;
    logic       mem_timeout;
    logic [3:0] dbg_state;

    // Handshake: MemRead/MemWrite stay asserted until the cycle mem_ready is high, and
    // that cycle completes the access; mem_ready is ignored outside memory states.
    modport master (
        input  opcode, funct, Zero, mem_ready,
        output ALUControl, ALUSrcA, ALUSrcB, ext_zero, PCSource, pc_en, IorD,
               MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
               instr_done, illegal_instr, mem_timeout, dbg_state
    );
    modport slave (
        output opcode, funct, Zero, mem_ready,
        input  ALUControl, ALUSrcA, ALUSrcB, ext_zero, PCSource, pc_en, IorD,
               MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
               instr_done, illegal_instr, mem_timeout, dbg_state
    );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS main control FSM: sequences fetch/decode/execute/memory/writeback and
// drives datapath selects, enables and ALU operation codes, with an optional memory stall limit.
module mips_multicycle_ctrl #(
    parameter int unsigned STALL_LIMIT = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    mips_multicycle_ctrl_if.master bus
);
    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC_R, EXEC_I, ALUWB, BRANCH, JUMP
    } state_t;

    localparam logic [5:0] OP_R = 6'h00, OP_J = 6'h02, OP_BEQ = 6'h04, OP_ADDI = 6'h08,
                           OP_SLTI = 6'h0A, OP_ANDI = 6'h0C, OP_ORI = 6'h0D,
                           OP_LW = 6'h23, OP_SW = 6'h2B;
    localparam logic [7:0] LIMIT_M1 = (STALL_LIMIT > 0) ? 8'(STALL_LIMIT - 1) : 8'd0;

    state_t     state_q, state_d;
    logic [7:0] stall_q, stall_d;
    logic       waiting, timeout, illegal;
    logic [4:0] r_dec;

    // {legal, ALU code} for an R-type funct field
    function automatic logic [4:0] r_map(input logic [5:0] f);
        case (f)
            6'h20, 6'h21: r_map = 5'b1_0000;
            6'h22, 6'h23: r_map = 5'b1_0001;
            6'h18:        r_map = 5'b1_0010;
            6'h1A:        r_map = 5'b1_0011;
            6'h00:        r_map = 5'b1_0100;
            6'h02:        r_map = 5'b1_0101;
            6'h24:        r_map = 5'b1_1000;
            6'h25:        r_map = 5'b1_1001;
            6'h26:        r_map = 5'b1_1010;
            6'h27:        r_map = 5'b1_1011;
            6'h2A:        r_map = 5'b1_1110;
            default:      r_map = 5'b0_0000;
        endcase
    endfunction

    assign r_dec         = r_map(bus.funct);
    assign bus.dbg_state = state_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            stall_q <= stall_d;
        end
    end

    always_comb begin
        state_d           = state_q;
        stall_d           = '0;
        illegal           = 1'b0;
        bus.ALUControl    = 4'b0000;
        bus.ALUSrcA       = 1'b0;
        bus.ALUSrcB       = 2'b00;
        bus.ext_zero      = 1'b0;
        bus.PCSource      = 2'b00;
        bus.pc_en         = 1'b0;
        bus.IorD          = 1'b0;
        bus.MemRead       = 1'b0;
        bus.MemWrite      = 1'b0;
        bus.IRWrite       = 1'b0;
        bus.RegDst        = 1'b0;
        bus.MemtoReg      = 1'b0;
        bus.RegWrite      = 1'b0;
        bus.instr_done    = 1'b0;
        bus.illegal_instr = 1'b0;
        bus.mem_timeout   = 1'b0;

        case (state_q)
            FETCH: begin
                bus.MemRead = 1'b1;
                bus.ALUSrcB = 2'b01;
                if (bus.mem_ready) begin
                    bus.IRWrite = 1'b1;
                    bus.pc_en   = 1'b1;
                    state_d     = DECODE;
                end
            end
            DECODE: begin
                // ALU precomputes the branch target into ALUOut regardless of opcode
                bus.ALUSrcB = 2'b11;
                case (bus.opcode)
                    OP_R:                             if (r_dec[4]) state_d = EXEC_R;
                                                      else illegal = 1'b1;
                    OP_LW, OP_SW:                     state_d = MEMADR;
                    OP_BEQ:                           state_d = BRANCH;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_d = EXEC_I;
                    OP_J:                             state_d = JUMP;
                    default:                          illegal = 1'b1;
                endcase
                if (illegal) begin
                    bus.illegal_instr = 1'b1;
                    bus.instr_done    = 1'b1;
                    state_d           = FETCH;
                end
            end
            EXEC_R: begin
                bus.ALUSrcA    = 1'b1;
                bus.ALUControl = r_dec[3:0];
                state_d        = ALUWB;
            end
            EXEC_I: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUSrcB = 2'b10;
                case (bus.opcode)
                    OP_ANDI: begin bus.ALUControl = 4'b1000; bus.ext_zero = 1'b1; end
                    OP_ORI:  begin bus.ALUControl = 4'b1001; bus.ext_zero = 1'b1; end
                    OP_SLTI: bus.ALUControl = 4'b1110;
                    default: bus.ALUControl = 4'b0000;
                endcase
                state_d = ALUWB;
            end
            ALUWB: begin
                bus.RegWrite   = 1'b1;
                bus.RegDst     = (bus.opcode == OP_R);
                bus.instr_done = 1'b1;
                state_d        = FETCH;
            end
            MEMADR: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUSrcB = 2'b10;
                state_d     = (bus.opcode == OP_SW) ? MEMWR : MEMRD;
            end
            MEMRD: begin
                bus.MemRead = 1'b1;
                bus.IorD    = 1'b1;
                if (bus.mem_ready) state_d = MEMWB;
            end
            MEMWB: begin
                bus.RegWrite   = 1'b1;
                bus.MemtoReg   = 1'b1;
                bus.instr_done = 1'b1;
                state_d        = FETCH;
            end
            MEMWR: begin
                bus.MemWrite = 1'b1;
                bus.IorD     = 1'b1;
                if (bus.mem_ready) begin
                    bus.instr_done = 1'b1;
                    state_d        = FETCH;
                end
            end
            BRANCH: begin
                bus.ALUSrcA    = 1'b1;
                bus.ALUControl = 4'b0001;
                bus.PCSource   = 2'b01;
                bus.pc_en      = bus.Zero;
                bus.instr_done = 1'b1;
                state_d        = FETCH;
            end
            JUMP: begin
                bus.PCSource   = 2'b10;
                bus.pc_en      = 1'b1;
                bus.instr_done = 1'b1;
                state_d        = FETCH;
            end
            default: state_d = FETCH;
        endcase

        // Stall tracking: the limit cycle itself aborts unless mem_ready arrives on it
        waiting = (state_q == FETCH || state_q == MEMRD || state_q == MEMWR) && !bus.mem_ready;
        timeout = (STALL_LIMIT != 0) && waiting && (stall_q == LIMIT_M1);
        if (timeout) begin
            bus.MemRead     = 1'b0;
            bus.MemWrite    = 1'b0;
            bus.mem_timeout = 1'b1;
            state_d         = FETCH;
        end else if (waiting) begin
            stall_d = (stall_q == 8'hFF) ? stall_q : stall_q + 8'd1;
        end

        if (reset) begin
            state_d           = FETCH;
            stall_d           = '0;
            bus.pc_en         = 1'b0;
            bus.MemRead       = 1'b0;
            bus.MemWrite      = 1'b0;
            bus.IRWrite       = 1'b0;
            bus.RegWrite      = 1'b0;
            bus.instr_done    = 1'b0;
            bus.illegal_instr = 1'b0;
            bus.mem_timeout   = 1'b0;
        end
    end
endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Bench for mips_multicycle_ctrl: a per-instruction trace model builds the expected
// output vector for every cycle from the instruction class and memory wait counts.
module tb_mips_multicycle_ctrl;
    localparam int LIMIT = 4;

    typedef struct packed {
        logic [3:0] alu;
        logic       srca;
        logic [1:0] srcb;
        logic       ext;
        logic [1:0] pcsrc;
        logic       pc_en;
        logic       iord;
        logic       mrd;
        logic       mwr;
        logic       irw;
        logic       regdst;
        logic       m2r;
        logic       rw;
        logic       done;
        logic       ill;
        logic       tmo;
    } outs_t;

    typedef struct packed {
        logic  mr;
        outs_t exp;
    } step_t;

    logic  clk = 1'b0;
    logic  reset;
    int    total = 0;
    int    bad = 0;
    step_t trace_q[$];
    outs_t obs_q[$];
    logic [3:0] rmap [logic [5:0]];
    logic [3:0] imap [logic [5:0]];

    mips_multicycle_ctrl_if bus();
    mips_multicycle_ctrl #(.STALL_LIMIT(LIMIT)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    function automatic outs_t sample();
        outs_t o;
        o.alu = bus.ALUControl;  o.srca = bus.ALUSrcA;   o.srcb = bus.ALUSrcB;
        o.ext = bus.ext_zero;    o.pcsrc = bus.PCSource; o.pc_en = bus.pc_en;
        o.iord = bus.IorD;       o.mrd = bus.MemRead;    o.mwr = bus.MemWrite;
        o.irw = bus.IRWrite;     o.regdst = bus.RegDst;  o.m2r = bus.MemtoReg;
        o.rw = bus.RegWrite;     o.done = bus.instr_done; o.ill = bus.illegal_instr;
        o.tmo = bus.mem_timeout;
        return o;
    endfunction

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic push(input logic mr, input outs_t e);
        step_t s;
        s.mr = mr;
        s.exp = e;
        trace_q.push_back(s);
    endtask

    // A memory access phase: w idle cycles then completion, unless the limit expires first
    task automatic mem_phase(input int w, input outs_t base, input outs_t fin, output logic ok);
        outs_t t;
        ok = 1'b1;
        for (int i = 0; i < w; i++) begin
            if (i + 1 == LIMIT) begin
                t = base; t.mrd = 1'b0; t.mwr = 1'b0; t.tmo = 1'b1;
                push(1'b0, t);
                ok = 1'b0;
                return;
            end
            push(1'b0, base);
        end
        push(1'b1, fin);
    endtask

    task automatic build(input logic [5:0] op, input logic [5:0] fn, input logic z,
                         input int wf, input int wm);
        outs_t t, f;
        logic ok;
        bus.opcode = op; bus.funct = fn; bus.Zero = z;
        trace_q.delete();
        f = '0; f.mrd = 1'b1; f.srcb = 2'b01;
        t = f; t.irw = 1'b1; t.pc_en = 1'b1;
        mem_phase(wf, f, t, ok);
        if (!ok) return;
        t = '0; t.srcb = 2'b11;
        if (!((op == 6'h00 && rmap.exists(fn)) || imap.exists(op) ||
              op == 6'h23 || op == 6'h2B || op == 6'h04 || op == 6'h02)) begin
            t.ill = 1'b1; t.done = 1'b1;
            push(rbit(), t);
            return;
        end
        push(rbit(), t);
        if (op == 6'h00 || imap.exists(op)) begin
            t = '0; t.srca = 1'b1;
            if (op == 6'h00) t.alu = rmap[fn];
            else begin
                t.alu = imap[op]; t.srcb = 2'b10; t.ext = (op == 6'h0C || op == 6'h0D);
            end
            push(rbit(), t);
            t = '0; t.rw = 1'b1; t.regdst = (op == 6'h00); t.done = 1'b1;
            push(rbit(), t);
        end else if (op == 6'h23 || op == 6'h2B) begin
            t = '0; t.srca = 1'b1; t.srcb = 2'b10;
            push(rbit(), t);
            f = '0; f.iord = 1'b1;
            if (op == 6'h23) begin
                f.mrd = 1'b1;
                mem_phase(wm, f, f, ok);
                if (!ok) return;
                t = '0; t.rw = 1'b1; t.m2r = 1'b1; t.done = 1'b1;
                push(rbit(), t);
            end else begin
                f.mwr = 1'b1; t = f; t.done = 1'b1;
                mem_phase(wm, f, t, ok);
            end
        end else if (op == 6'h04) begin
            t = '0; t.srca = 1'b1; t.alu = 4'b0001; t.pcsrc = 2'b01; t.pc_en = z; t.done = 1'b1;
            push(rbit(), t);
        end else begin
            t = '0; t.pcsrc = 2'b10; t.pc_en = 1'b1; t.done = 1'b1;
            push(rbit(), t);
        end
    endtask

    // Drives each cycle's mem_ready just after the edge and records outputs at the falling edge
    task automatic drive_trace();
        obs_q.delete();
        foreach (trace_q[i]) begin
            bus.mem_ready = trace_q[i].mr;
            @(negedge clk);
            obs_q.push_back(sample());
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        outs_t e, o;
        reset = 1'b1; bus.mem_ready = 1'b1; bus.opcode = '0; bus.funct = '0; bus.Zero = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        o = sample();
        e = '0; e.srcb = 2'b01;
        total++;
        if (o !== e) begin bad++; $display("FAIL reset got=%h exp=%h", o, e); end
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_add();
        build(6'h00, 6'h20, 1'b0, 0, 0);
        drive_trace();
        foreach (trace_q[i]) begin
            total++;
            if (obs_q[i] !== trace_q[i].exp) begin
                bad++; $display("FAIL add cyc%0d got=%h exp=%h", i, obs_q[i], trace_q[i].exp);
            end
        end
        total++;
        if (obs_q[3].done !== 1'b1 || obs_q[2].done !== 1'b0) begin
            bad++; $display("FAIL add_done got=%b%b exp=01", obs_q[2].done, obs_q[3].done);
        end
    endtask

    task automatic test_lw_stall();
        build(6'h23, 6'h00, 1'b0, 0, 3);
        drive_trace();
        foreach (trace_q[i]) begin
            total++;
            if (obs_q[i] !== trace_q[i].exp) begin
                bad++; $display("FAIL lw_stall cyc%0d got=%h exp=%h", i, obs_q[i], trace_q[i].exp);
            end
        end
        total++;
        if (obs_q.size() != 8 || obs_q[7].m2r !== 1'b1) begin
            bad++; $display("FAIL lw_len got=%0d exp=8", obs_q.size());
        end
    endtask

    task automatic test_beq();
        for (int z = 1; z >= 0; z--) begin
            build(6'h04, 6'h00, 1'(z), 0, 0);
            drive_trace();
            foreach (trace_q[i]) begin
                total++;
                if (obs_q[i] !== trace_q[i].exp) begin
                    bad++; $display("FAIL beq_z%0d cyc%0d got=%h exp=%h", z, i, obs_q[i], trace_q[i].exp);
                end
            end
            total++;
            if (obs_q[2].pc_en !== 1'(z)) begin
                bad++; $display("FAIL beq_pc_en got=%b exp=%0d", obs_q[2].pc_en, z);
            end
        end
    endtask

    task automatic test_illegal();
        logic [5:0] ops [2];
        logic [5:0] fns [2];
        ops[0] = 6'h3F; fns[0] = 6'h20;
        ops[1] = 6'h00; fns[1] = 6'h3F;
        for (int k = 0; k < 2; k++) begin
            build(ops[k], fns[k], 1'b0, 0, 0);
            drive_trace();
            foreach (trace_q[i]) begin
                total++;
                if (obs_q[i] !== trace_q[i].exp) begin
                    bad++; $display("FAIL illegal%0d cyc%0d got=%h exp=%h", k, i, obs_q[i], trace_q[i].exp);
                end
            end
        end
    endtask

    task automatic test_timeout();
        build(6'h00, 6'h20, 1'b0, 6, 0);
        drive_trace();
        foreach (trace_q[i]) begin
            total++;
            if (obs_q[i] !== trace_q[i].exp) begin
                bad++; $display("FAIL fetch_tmo cyc%0d got=%h exp=%h", i, obs_q[i], trace_q[i].exp);
            end
        end
        build(6'h23, 6'h00, 1'b0, 1, 5);
        drive_trace();
        foreach (trace_q[i]) begin
            total++;
            if (obs_q[i] !== trace_q[i].exp) begin
                bad++; $display("FAIL memrd_tmo cyc%0d got=%h exp=%h", i, obs_q[i], trace_q[i].exp);
            end
        end
    endtask

    task automatic test_reset_memwr();
        outs_t e, o;
        build(6'h2B, 6'h00, 1'b0, 0, 0);
        while (trace_q.size() > 3) void'(trace_q.pop_back());
        drive_trace();
        foreach (trace_q[i]) begin
            total++;
            if (obs_q[i] !== trace_q[i].exp) begin
                bad++; $display("FAIL sw_pre cyc%0d got=%h exp=%h", i, obs_q[i], trace_q[i].exp);
            end
        end
        reset = 1'b1; bus.mem_ready = 1'b1;
        @(negedge clk);
        o = sample();
        e = '0; e.iord = 1'b1;
        total++;
        if (o !== e) begin bad++; $display("FAIL reset_memwr got=%h exp=%h", o, e); end
        @(posedge clk);
        #1;
        reset = 1'b0;
        build(6'h0D, 6'h00, 1'b0, 0, 0);
        drive_trace();
        foreach (trace_q[i]) begin
            total++;
            if (obs_q[i] !== trace_q[i].exp) begin
                bad++; $display("FAIL ori cyc%0d got=%h exp=%h", i, obs_q[i], trace_q[i].exp);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [5:0] ops [11];
        logic [5:0] fns [13];
        logic [5:0] op, fn;
        int wf, wm;
        ops = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h08, 6'h0C, 6'h0D, 6'h0A, 6'h02, 6'h3F, 6'h05};
        fns = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h18, 6'h1A, 6'h00, 6'h02, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A};
        for (int n = 0; n < 60; n++) begin
            op = ops[$urandom_range(0, 10)];
            fn = ($urandom_range(0, 7) == 0) ? 6'h3B : fns[$urandom_range(0, 12)];
            wf = ($urandom_range(0, 9) == 0) ? 5 : $urandom_range(0, 2);
            wm = ($urandom_range(0, 9) == 0) ? 5 : $urandom_range(0, 3);
            build(op, fn, rbit(), wf, wm);
            drive_trace();
            foreach (trace_q[i]) begin
                total++;
                if (obs_q[i] !== trace_q[i].exp) begin
                    bad++;
                    $display("FAIL rand%0d op=%h fn=%h cyc%0d got=%h exp=%h", n, op, fn, i, obs_q[i], trace_q[i].exp);
                end
            end
        end
    endtask

    initial begin
        rmap[6'h20] = 4'b0000; rmap[6'h21] = 4'b0000; rmap[6'h22] = 4'b0001; rmap[6'h23] = 4'b0001;
        rmap[6'h18] = 4'b0010; rmap[6'h1A] = 4'b0011; rmap[6'h00] = 4'b0100; rmap[6'h02] = 4'b0101;
        rmap[6'h24] = 4'b1000; rmap[6'h25] = 4'b1001; rmap[6'h26] = 4'b1010; rmap[6'h27] = 4'b1011;
        rmap[6'h2A] = 4'b1110;
        imap[6'h08] = 4'b0000; imap[6'h0C] = 4'b1000; imap[6'h0D] = 4'b1001; imap[6'h0A] = 4'b1110;
        test_reset();
        test_add();
        test_lw_stall();
        test_beq();
        test_illegal();
        test_timeout();
        test_reset_memwr();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
